// File: rtl/clkdiv_seq_ctrl_if.sv
// Control/status bundle between board registers, the /2-/4-/8 divider and its sequencer.
// Signal names follow the board-level pin names.
interface clkdiv_seq_ctrl_if;
  logic       START;
  logic       STOP;
  logic [1:0] SEL;
  logic       DIV_FB;
  logic       MR;
  logic       EN_;
  logic [1:0] DIV_SEL;
  logic       BUSY;
  logic       LOCKED;
  logic       ERR;
  logic [1:0] ERR_CODE;

  modport slave (
    input  START, STOP, SEL, DIV_FB,
    output MR, EN_, DIV_SEL, BUSY, LOCKED, ERR, ERR_CODE
  );

  modport master (
    output START, STOP, SEL, DIV_FB,
    input  MR, EN_, DIV_SEL, BUSY, LOCKED, ERR, ERR_CODE
  );
endinterface

// File: rtl/clkdiv_seq_ctrl.sv
// Reset/enable sequencer for the ECL clock divider: drives MR/EN_, selects the ratio,
// then checks the fed-back divided clock edge count per window and reports lock or error.
module clkdiv_seq_ctrl #(
  parameter int MR_CYCLES     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int WINDOW        = 64,
  parameter int TOL           = 1
) (
  input  logic CLK,
  input  logic RST_,
  clkdiv_seq_ctrl_if.slave bus
);
  localparam int WW = $clog2(WINDOW);
  localparam int CW = WW + 1;
  localparam int PW = $clog2(MR_CYCLES > SETTLE_CYCLES ? MR_CYCLES : SETTLE_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MRST, S_SETTLE, S_CHECK, S_LOCK, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [WW-1:0] win_q, win_d;
  logic [CW-1:0] edge_q, edge_d;
  logic [2:0]    sync_q, sync_d;
  logic [1:0]    div_sel_q, div_sel_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          mr_q, mr_d, en_n_q, en_n_d, busy_q, busy_d;
  logic          locked_q, locked_d, err_q, err_d;

  logic          rise;
  logic [CW-1:0] edge_inc, exp_cnt, diff;
  logic          win_end, in_tol;

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      win_q      <= '0;
      edge_q     <= '0;
      sync_q     <= '0;
      div_sel_q  <= '0;
      err_code_q <= '0;
      mr_q       <= 1'b1;
      en_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      win_q      <= win_d;
      edge_q     <= edge_d;
      sync_q     <= sync_d;
      div_sel_q  <= div_sel_d;
      err_code_q <= err_code_d;
      mr_q       <= mr_d;
      en_n_q     <= en_n_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  // sync_q[1] is the last synchronizer stage, sync_q[2] the edge-detect delay.
  always_comb begin
    sync_d   = {sync_q[1:0], bus.DIV_FB};
    rise     = sync_q[1] & ~sync_q[2];
    edge_inc = (&edge_q) ? edge_q : edge_q + CW'(rise);
    win_end  = (win_q == WW'(WINDOW - 1));
    exp_cnt  = CW'(WINDOW >> ({1'b0, div_sel_q} + 3'd1));
    diff     = (edge_inc >= exp_cnt) ? edge_inc - exp_cnt : exp_cnt - edge_inc;
    in_tol   = (diff <= CW'(TOL));

    state_d    = state_q;
    ph_d       = ph_q;
    win_d      = win_q;
    edge_d     = edge_q;
    div_sel_d  = div_sel_q;
    err_code_d = err_code_q;

    if (bus.STOP) begin
      state_d    = S_IDLE;
      err_code_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (bus.START) begin
            div_sel_d = bus.SEL;
            ph_d      = '0;
            if (bus.SEL == 2'd3) begin
              state_d    = S_ERROR;
              err_code_d = 2'd1;
            end else begin
              state_d    = S_MRST;
              err_code_d = 2'd0;
            end
          end
        end
        S_MRST: begin
          if (ph_q == PW'(MR_CYCLES - 1)) begin
            state_d = S_SETTLE;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        S_SETTLE: begin
          win_d  = '0;
          edge_d = '0;
          if (ph_q == PW'(SETTLE_CYCLES - 1)) state_d = S_CHECK;
          else                                ph_d    = ph_q + 1'b1;
        end
        S_CHECK, S_LOCK: begin
          // Window counter is exactly WW bits, so it wraps to 0 on its own.
          win_d  = win_q + 1'b1;
          edge_d = edge_inc;
          if (win_end) begin
            edge_d = '0;
            if (in_tol) begin
              state_d = S_LOCK;
            end else begin
              state_d    = S_ERROR;
              err_code_d = 2'd2;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    mr_d     = 1'b1;
    en_n_d   = 1'b1;
    busy_d   = 1'b0;
    locked_d = 1'b0;
    err_d    = 1'b0;
    case (state_d)
      S_MRST:   busy_d = 1'b1;
      S_SETTLE: begin mr_d = 1'b0; busy_d = 1'b1; end
      S_CHECK:  begin mr_d = 1'b0; en_n_d = 1'b0; busy_d = 1'b1; end
      S_LOCK:   begin mr_d = 1'b0; en_n_d = 1'b0; locked_d = 1'b1; end
      S_ERROR:  err_d = 1'b1;
      default:  ;
    endcase
  end

  assign bus.MR       = mr_q;
  assign bus.EN_      = en_n_q;
  assign bus.DIV_SEL  = div_sel_q;
  assign bus.BUSY     = busy_q;
  assign bus.LOCKED   = locked_q;
  assign bus.ERR      = err_q;
  assign bus.ERR_CODE = err_code_q;
endmodule
